// File: rtl/keypad_operand_loader.sv
// 4x4 hex keypad scanner/debouncer that loads two operands (A then B) for the adder path.
// Optional KEY_ECHO_EN adds Key_code/Key_strobe echo outputs for every accepted key.
module keypad_operand_loader #(
  parameter int unsigned SCAN_DWELL      = 4,
  parameter int unsigned DEBOUNCE_CYCLES = 8,
  parameter int unsigned CNT_W           = 4
) (
  input  logic       Clk,
  input  logic       Rst_n,
  input  logic [3:0] Row,
  output logic [3:0] Col,
  output logic [3:0] A,
  output logic [3:0] B,
  output logic       Sel_B,
  output logic       Ops_valid
`ifdef KEY_ECHO_EN
  ,
  output logic [3:0] Key_code,
  output logic       Key_strobe
`endif
);

  typedef enum logic [1:0] {
    StScan,
    StDebounce,
    StWaitRelease
  } state_e;

  localparam logic [CNT_W-1:0] DwellLast = CNT_W'(SCAN_DWELL - 1);
  localparam logic [CNT_W-1:0] DebLast   = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CntOne    = CNT_W'(1);

  // Row synchronizer
  logic [3:0] row_meta_q, rs_q;

  // Scan / debounce control
  state_e           state_q, state_d;
  logic [1:0]       col_idx_q, col_idx_d;
  logic [CNT_W-1:0] dwell_q, dwell_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       pattern_q, pattern_d;
  logic             accept;

  // Operand datapath
  logic [3:0] a_q, a_d;
  logic [3:0] b_q, b_d;
  logic       sel_b_q, sel_b_d;
  logic       ops_valid_q, ops_valid_d;
  logic [1:0] key_row;
  logic [3:0] key_code;

  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      row_meta_q <= 4'hF;
      rs_q       <= 4'hF;
    end else begin
      row_meta_q <= Row;
      rs_q       <= row_meta_q;
    end
  end

  // State register
  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      state_q   <= StScan;
      col_idx_q <= 2'd0;
      dwell_q   <= '0;
      cnt_q     <= '0;
      pattern_q <= 4'hF;
    end else begin
      state_q   <= state_d;
      col_idx_q <= col_idx_d;
      dwell_q   <= dwell_d;
      cnt_q     <= cnt_d;
      pattern_q <= pattern_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d   = state_q;
    col_idx_d = col_idx_q;
    dwell_d   = dwell_q;
    cnt_d     = cnt_q;
    pattern_d = pattern_q;
    accept    = 1'b0;
    unique case (state_q)
      StScan: begin
        if (dwell_q == DwellLast) begin
          dwell_d = '0;
          if (rs_q != 4'hF) begin
            state_d   = StDebounce;
            pattern_d = rs_q;
            cnt_d     = CntOne;
          end else begin
            col_idx_d = col_idx_q + 2'd1;
          end
        end else begin
          dwell_d = dwell_q + CntOne;
        end
      end
      StDebounce: begin
        if (rs_q == 4'hF) begin
          state_d   = StScan;
          col_idx_d = col_idx_q + 2'd1;
          dwell_d   = '0;
          cnt_d     = '0;
        end else if (rs_q != pattern_q) begin
          pattern_d = rs_q;
          cnt_d     = CntOne;
        end else if (cnt_q == DebLast) begin
          // This sample brings the stable count to DEBOUNCE_CYCLES.
          accept  = 1'b1;
          state_d = StWaitRelease;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CntOne;
        end
      end
      StWaitRelease: begin
        if (rs_q != 4'hF) begin
          cnt_d = '0;
        end else if (cnt_q == DebLast) begin
          state_d   = StScan;
          col_idx_d = 2'd0;
          dwell_d   = '0;
          cnt_d     = '0;
        end else begin
          cnt_d = cnt_q + CntOne;
        end
      end
      default: begin
        state_d = StScan;
      end
    endcase
  end

  // Output logic: column drive follows the registered column index
  always_comb begin
    Col = ~(4'b0001 << col_idx_q);
  end

  // Lowest low row wins when several rows are pressed in the held column.
  always_comb begin
    if (!pattern_q[0]) begin
      key_row = 2'd0;
    end else if (!pattern_q[1]) begin
      key_row = 2'd1;
    end else if (!pattern_q[2]) begin
      key_row = 2'd2;
    end else begin
      key_row = 2'd3;
    end
    key_code = {key_row, col_idx_q};
  end

  always_comb begin
    a_d         = a_q;
    b_d         = b_q;
    sel_b_d     = sel_b_q;
    ops_valid_d = 1'b0;
    if (accept) begin
      if (!sel_b_q) begin
        a_d     = key_code;
        sel_b_d = 1'b1;
      end else begin
        b_d         = key_code;
        sel_b_d     = 1'b0;
        ops_valid_d = 1'b1;
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      a_q         <= 4'h0;
      b_q         <= 4'h0;
      sel_b_q     <= 1'b0;
      ops_valid_q <= 1'b0;
    end else begin
      a_q         <= a_d;
      b_q         <= b_d;
      sel_b_q     <= sel_b_d;
      ops_valid_q <= ops_valid_d;
    end
  end

  assign A         = a_q;
  assign B         = b_q;
  assign Sel_B     = sel_b_q;
  assign Ops_valid = ops_valid_q;

`ifdef KEY_ECHO_EN
  logic [3:0] key_code_q;
  logic       key_strobe_q;

  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      key_code_q   <= 4'h0;
      key_strobe_q <= 1'b0;
    end else begin
      key_strobe_q <= accept;
      if (accept) begin
        key_code_q <= key_code;
      end
    end
  end

  assign Key_code   = key_code_q;
  assign Key_strobe = key_strobe_q;
`endif

endmodule

// File: tb/tb_keypad_operand_loader.sv
// Scoreboard bench for keypad_operand_loader: a keypad model drives Row from Col and
// the press map; expected loads are queued at press time and checked by a monitor.
module tb_keypad_operand_loader;

  localparam int unsigned ScanDwell = 4;
  localparam int unsigned DebCycles = 8;
  localparam int LatMin = 2 + DebCycles;
  localparam int LatMax = 2 + 4 * ScanDwell + DebCycles + 1;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] row;
  logic [3:0] col;
  logic [3:0] a, b;
  logic       sel_b, ops_valid;
`ifdef KEY_ECHO_EN
  logic [3:0] key_code;
  logic       key_strobe;
`endif

  // press[c] has a 1 for each row shorted to column c
  logic [3:0][3:0] press = '0;

  int cyc = 0;
  int n_checks = 0;
  int n_pass = 0;

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic       sel;
    logic       ops;
    int         t0;
  } exp_t;

  exp_t sb[$];

  keypad_operand_loader #(
    .SCAN_DWELL      (ScanDwell),
    .DEBOUNCE_CYCLES (DebCycles),
    .CNT_W           (4)
  ) dut (
    .Clk       (clk),
    .Rst_n     (rst_n),
    .Row       (row),
    .Col       (col),
    .A         (a),
    .B         (b),
    .Sel_B     (sel_b),
    .Ops_valid (ops_valid)
`ifdef KEY_ECHO_EN
    ,
    .Key_code  (key_code),
    .Key_strobe(key_strobe)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always_comb begin
    row = 4'hF;
    for (int c = 0; c < 4; c++) begin
      if (!col[c]) row = row & ~press[c];
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic expect_key(input logic [3:0] ea, input logic [3:0] eb, input logic es,
                            input logic eo);
    exp_t e;
    e.a = ea;
    e.b = eb;
    e.sel = es;
    e.ops = eo;
    e.t0 = cyc;
    sb.push_back(e);
  endtask

  // Monitor: any Sel_B toggle or Ops_valid pulse is an acceptance; reset edges are skipped.
  logic rst_prev = 1'b0;
  logic sel_prev = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    int lat;
    if (rst_prev && ((sel_b !== sel_prev) || (ops_valid !== 1'b0))) begin
      if (sb.size() == 0) begin
        check("spurious_accept", sb.size(), 1);
      end else begin
        e = sb.pop_front();
        lat = cyc - e.t0;
        check("A", a, e.a);
        check("B", b, e.b);
        check("Sel_B", sel_b, e.sel);
        check("Ops_valid", ops_valid, e.ops);
        check("latency_min", lat >= LatMin, 1);
        check("latency_max", lat <= LatMax, 1);
      end
    end
    rst_prev = rst_n;
    sel_prev = sel_b;
  end

  initial begin
    logic [3:0] ec;
    tick(3);
    rst_n = 1'b1;
    check("rst_A", a, 4'h0);
    check("rst_B", b, 4'h0);
    check("rst_Sel_B", sel_b, 1'b0);
    check("rst_Ops_valid", ops_valid, 1'b0);
    check("rst_Col", col, 4'b1110);

    // Idle scan: each column low for ScanDwell cycles in order 0..3
    for (int k = 0; k < 32; k++) begin
      ec = ~(4'b0001 << ((k / ScanDwell) % 4));
      check("idle_Col", col, ec);
      tick(1);
    end
    tick(68);

    // Row1/col2 -> A=6, then row3/col3 -> B=F with Ops_valid
    press[2] = 4'b0010;
    expect_key(4'h6, 4'h0, 1'b1, 1'b0);
    tick(40);
    press[2] = 4'b0000;
    tick(20);
    press[3] = 4'b1000;
    expect_key(4'h6, 4'hF, 1'b0, 1'b1);
    tick(40);
    press[3] = 4'b0000;
    tick(20);

    // Bounce on row0/col1: nothing may be accepted until it settles
    for (int i = 0; i < 10; i++) begin
      press[1] = (i % 2 == 0) ? 4'b0001 : 4'b0000;
      tick(3);
    end
    press[1] = 4'b0001;
    expect_key(4'h1, 4'hF, 1'b1, 1'b0);
    tick(40);

    // One-cycle reset while waiting for release
    rst_n = 1'b0;
    tick(1);
    rst_n = 1'b1;
    press[1] = 4'b0000;
    check("mid_rst_A", a, 4'h0);
    check("mid_rst_B", b, 4'h0);
    check("mid_rst_Sel_B", sel_b, 1'b0);
    check("mid_rst_Ops_valid", ops_valid, 1'b0);
    check("mid_rst_Col", col, 4'b1110);
    tick(4);
    check("mid_rst_scan_Col", col, 4'b1101);

    // Long hold on row2/col0: exactly one acceptance
    press[0] = 4'b0100;
    expect_key(4'h8, 4'h0, 1'b1, 1'b0);
    tick(200);
    press[0] = 4'b0000;
    tick(20);

    // Rows 1 and 2 together in col1: lowest row wins -> 5
    press[1] = 4'b0110;
    expect_key(4'h8, 4'h5, 1'b0, 1'b1);
    tick(40);
    press[1] = 4'b0000;
    tick(20);

    check("scoreboard_drained", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
